// File: rtl/regfile_array.sv
// regfile_array: byte-addressable register pairs with SP, PC, pair ops and an address latch.
// Byte 2k is the high half of pair k; pair ops override same-cycle byte writes.
module regfile_array #(
   parameter int DATA_W    = 8,
   parameter int NUM_PAIRS = 3,
   parameter int RESET_PC  = 0,
   parameter int XCHG_A    = 1,
   parameter int XCHG_B    = 2,
   localparam int NUM_REGS = 2 * NUM_PAIRS,
   localparam int RSEL_W   = $clog2(NUM_REGS),
   localparam int PSEL_W   = $clog2(NUM_PAIRS + 2),
   localparam int W        = 2 * DATA_W
) (
   input  logic              clk50M_i,
   input  logic              rst_ni,
   input  logic              wr8_en_i,
   input  logic [RSEL_W-1:0] wr8_sel_i,
   input  logic [DATA_W-1:0] wr8_data_i,
   input  logic [RSEL_W-1:0] rd_sel_a_i,
   input  logic [RSEL_W-1:0] rd_sel_b_i,
   output logic [DATA_W-1:0] rd_data_a_o,
   output logic [DATA_W-1:0] rd_data_b_o,
   input  logic [2:0]        pair_op_i,
   input  logic [PSEL_W-1:0] pair_sel_i,
   input  logic [W-1:0]      pair_data_i,
   input  logic              pc_inc_i,
   input  logic              addr_latch_i,
   input  logic [PSEL_W-1:0] addr_sel_i,
   output logic [W-1:0]      addr_o,
   output logic              pair_zero_o
);
   logic [DATA_W-1:0] reg_q [NUM_REGS];
   logic [DATA_W-1:0] reg_d [NUM_REGS];
   logic [W-1:0] sp_q, sp_d, pc_q, pc_d, addr_q, addr_d, cur, res;
   logic zero_q, zero_d, op_ok, arith;

   function automatic logic [W-1:0] pair_val(input logic [PSEL_W-1:0] s);
      pair_val = '0;
      for (int k = 0; k < NUM_PAIRS; k++)
         if (int'(s) == k) pair_val = {reg_q[2*k], reg_q[2*k+1]};
      if (int'(s) == NUM_PAIRS) pair_val = sp_q;
      if (int'(s) == NUM_PAIRS + 1) pair_val = pc_q;
   endfunction

   assign rd_data_a_o = (int'(rd_sel_a_i) < NUM_REGS) ? reg_q[rd_sel_a_i] : '0;
   assign rd_data_b_o = (int'(rd_sel_b_i) < NUM_REGS) ? reg_q[rd_sel_b_i] : '0;
   assign addr_o      = addr_q;
   assign pair_zero_o = zero_q;

   always_comb begin
      cur   = pair_val(pair_sel_i);
      op_ok = (pair_op_i inside {3'd1, 3'd2, 3'd3}) && int'(pair_sel_i) <= NUM_PAIRS + 1;
      arith = op_ok && pair_op_i != 3'd3;
      res   = pair_op_i == 3'd1 ? cur + 1'b1 : pair_op_i == 3'd2 ? cur - 1'b1 : pair_data_i;
      reg_d = reg_q;
      sp_d  = sp_q;
      pc_d  = pc_inc_i ? pc_q + 1'b1 : pc_q;
      if (wr8_en_i && int'(wr8_sel_i) < NUM_REGS) reg_d[wr8_sel_i] = wr8_data_i;
      // XCHG is written last among byte updates so it beats any same-cycle wr8
      if (pair_op_i == 3'd4) begin
         reg_d[2*XCHG_A]   = reg_q[2*XCHG_B];
         reg_d[2*XCHG_A+1] = reg_q[2*XCHG_B+1];
         reg_d[2*XCHG_B]   = reg_q[2*XCHG_A];
         reg_d[2*XCHG_B+1] = reg_q[2*XCHG_A+1];
      end
      for (int k = 0; k < NUM_PAIRS; k++)
         if (op_ok && int'(pair_sel_i) == k) begin
            reg_d[2*k]   = res[W-1:DATA_W];
            reg_d[2*k+1] = res[DATA_W-1:0];
         end
      if (op_ok && int'(pair_sel_i) == NUM_PAIRS) sp_d = res;
      if (op_ok && int'(pair_sel_i) == NUM_PAIRS + 1) pc_d = res;
      zero_d = arith ? (res == '0) : zero_q;
      addr_d = addr_latch_i ? pair_val(addr_sel_i) : addr_q;
   end

   always_ff @(posedge clk50M_i) begin
      if (!rst_ni) begin
         reg_q  <= '{default: '0};
         sp_q   <= '0;
         pc_q   <= W'(RESET_PC);
         addr_q <= '0;
         zero_q <= 1'b0;
      end else begin
         reg_q  <= reg_d;
         sp_q   <= sp_d;
         pc_q   <= pc_d;
         addr_q <= addr_d;
         zero_q <= zero_d;
      end
   end
endmodule

// File: tb/tb_regfile_array.sv
// tb_regfile_array: directed checks of byte/pair access, pair ops, PC and reset.
module tb_regfile_array;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr8_en;
   logic [2:0]  wr8_sel;
   logic [7:0]  wr8_data;
   logic [2:0]  rd_sel_a, rd_sel_b;
   logic [7:0]  rd_a, rd_b;
   logic [2:0]  pair_op;
   logic [2:0]  pair_sel;
   logic [15:0] pair_data;
   logic        pc_inc, addr_latch;
   logic [2:0]  addr_sel;
   logic [15:0] addr;
   logic        zero;
   int checks = 0;
   int errors = 0;

   regfile_array #(.RESET_PC(16'h0100)) dut (
      .clk50M_i(clk), .rst_ni(rst_n),
      .wr8_en_i(wr8_en), .wr8_sel_i(wr8_sel), .wr8_data_i(wr8_data),
      .rd_sel_a_i(rd_sel_a), .rd_sel_b_i(rd_sel_b),
      .rd_data_a_o(rd_a), .rd_data_b_o(rd_b),
      .pair_op_i(pair_op), .pair_sel_i(pair_sel), .pair_data_i(pair_data),
      .pc_inc_i(pc_inc), .addr_latch_i(addr_latch), .addr_sel_i(addr_sel),
      .addr_o(addr), .pair_zero_o(zero)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr8_en = 1'b0; pair_op = 3'd0; pc_inc = 1'b0; addr_latch = 1'b0;
   endtask

   task automatic op(input logic [2:0] o, input logic [2:0] s, input logic [15:0] d);
      pair_op = o; pair_sel = s; pair_data = d;
      step();
      idle();
   endtask

   task automatic wr(input logic [2:0] s, input logic [7:0] d);
      wr8_en = 1'b1; wr8_sel = s; wr8_data = d;
      step();
      idle();
   endtask

   task automatic latch_chk(input string tag, input logic [2:0] s, input logic [15:0] exp);
      addr_latch = 1'b1; addr_sel = s;
      step();
      idle();
      chk(tag, 32'(addr), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; idle();
      wr8_sel = '0; wr8_data = '0; rd_sel_a = '0; rd_sel_b = '0;
      pair_sel = '0; pair_data = '0; addr_sel = '0;
      step(); step();
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_zero", 32'(zero), 32'h0);
      chk("rst_byte0", 32'(rd_a), 32'h0);
      rst_n = 1'b1;
      latch_chk("rst_pc", 3'd4, 16'h0100);
      wr(3'd4, 8'h12);
      wr(3'd5, 8'h34);
      rd_sel_a = 3'd4; rd_sel_b = 3'd5; #1;
      chk("rd_h", 32'(rd_a), 32'h12);
      chk("rd_l", 32'(rd_b), 32'h34);
      rd_sel_a = 3'd7; #1;
      chk("rd_oor", 32'(rd_a), 32'h0);
      latch_chk("hl_latch", 3'd2, 16'h1234);
      op(3'd3, 3'd3, 16'hFFFF);
      op(3'd1, 3'd3, 16'h0);
      chk("inc_zero", 32'(zero), 32'h1);
      latch_chk("sp_wrap", 3'd3, 16'h0000);
      chk("zero_hold", 32'(zero), 32'h1);
      op(3'd1, 3'd7, 16'h0);
      chk("oor_op_zero", 32'(zero), 32'h1);
      op(3'd2, 3'd3, 16'h0);
      chk("dec_zero", 32'(zero), 32'h0);
      latch_chk("sp_dec", 3'd3, 16'hFFFF);
      latch_chk("latch_oor", 3'd6, 16'h0000);
      op(3'd3, 3'd1, 16'hAAAA);
      op(3'd3, 3'd2, 16'h5555);
      op(3'd4, 3'd0, 16'h0);
      latch_chk("xchg_de", 3'd1, 16'h5555);
      latch_chk("xchg_hl", 3'd2, 16'hAAAA);
      rd_sel_a = 3'd2; rd_sel_b = 3'd4; #1;
      chk("xchg_d", 32'(rd_a), 32'h55);
      chk("xchg_h", 32'(rd_b), 32'hAA);
      op(3'd3, 3'd2, 16'h00FF);
      wr8_en = 1'b1; wr8_sel = 3'd5; wr8_data = 8'h99;
      op(3'd1, 3'd2, 16'h0);
      latch_chk("pair_wins", 3'd2, 16'h0100);
      wr8_en = 1'b1; wr8_sel = 3'd0; wr8_data = 8'h77;
      op(3'd1, 3'd2, 16'h0);
      rd_sel_a = 3'd0; #1;
      chk("wr8_other", 32'(rd_a), 32'h77);
      latch_chk("hl_inc2", 3'd2, 16'h0101);
      pc_inc = 1'b1;
      step(); idle();
      latch_chk("pc_inc", 3'd4, 16'h0101);
      pc_inc = 1'b1; addr_latch = 1'b1; addr_sel = 3'd4;
      op(3'd3, 3'd4, 16'h2000);
      chk("latch_old_pc", 32'(addr), 32'h0101);
      latch_chk("pc_load", 3'd4, 16'h2000);
      op(3'd3, 3'd3, 16'hFFFF);
      op(3'd1, 3'd3, 16'h0);
      chk("pre_rst_zero", 32'(zero), 32'h1);
      rst_n = 1'b0; pc_inc = 1'b1; wr8_en = 1'b1; wr8_sel = 3'd1; wr8_data = 8'h5A;
      addr_latch = 1'b1; addr_sel = 3'd4;
      op(3'd1, 3'd4, 16'h0);
      rst_n = 1'b1;
      chk("mid_rst_addr", 32'(addr), 32'h0);
      chk("mid_rst_zero", 32'(zero), 32'h0);
      for (int i = 0; i < 6; i++) begin
         rd_sel_a = 3'(i); #1;
         chk($sformatf("mid_rst_byte%0d", i), 32'(rd_a), 32'h0);
      end
      latch_chk("mid_rst_sp", 3'd3, 16'h0000);
      latch_chk("mid_rst_pc", 3'd4, 16'h0100);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
